// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, score limits, speed thresholds and saturating helpers for the catch-ball game
package game_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_PAUSE = 2'd2, ST_OVER = 2'd3} game_state_t;
  localparam logic [7:0] SCORE_MAX = 8'd99;
  localparam logic [7:0] LVL1_TH = 8'd10;
  localparam logic [7:0] LVL2_TH = 8'd20;
  localparam logic [7:0] LVL3_TH = 8'd30;
  localparam int SLOT_W = 3;
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc, input logic [7:0] max);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return (sum > {1'b0, max}) ? max : sum[7:0];
  endfunction
  function automatic logic [1:0] level_of(input logic [7:0] s);
    return (s >= LVL3_TH) ? 2'd3 : (s >= LVL2_TH) ? 2'd2 : (s >= LVL1_TH) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: game tick divider, period TICK_DIV>>level, counting while run, frozen while hold, cleared otherwise
module game_tick_gen #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       hold,
  input  logic [1:0] level,
  output logic       tick
);
  logic [31:0] cnt;
  logic [31:0] term;
  assign term = (32'(TICK_DIV) >> level) - 32'd1;
  // >= so a level increase that shrinks term below cnt still wraps immediately
  assign tick = run && (cnt >= term);
  always_ff @(posedge clk) begin
    if (!reset || !(run || hold)) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 32'd1;
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: catch-ball game FSM, per-tick slot sweep over req/ack, score/miss/high-score/speed tracking
module game_sequencer #(
  parameter int unsigned NUM_SLOTS  = 5,
  parameter int unsigned TICK_DIV   = 5000000,
  parameter int unsigned MISS_LIMIT = 10,
  parameter logic [7:0]  SCORE_MAX  = game_pkg::SCORE_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_sw,
  output logic       upd_req,
  output logic [2:0] upd_slot,
  input  logic       upd_ack,
  input  logic       upd_caught,
  input  logic       upd_bonus,
  input  logic       upd_missed,
  output logic [1:0] game_state,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [7:0] missed,
  output logic [1:0] speed_level,
  output logic       sweep_done,
  output logic       overrun
);
  import game_pkg::*;
  game_state_t state;
  logic tick, go, ack, last, hit, miss;
  assign game_state = state;
  assign go   = start && (state == ST_IDLE || state == ST_OVER);
  assign ack  = upd_req && upd_ack;
  assign last = upd_slot == SLOT_W'(NUM_SLOTS - 1);
  // a simultaneous caught+missed report counts as a miss
  assign hit  = ack && upd_caught && !upd_missed;
  assign miss = ack && upd_missed;
  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .run(state == ST_PLAY),
    .hold(state == ST_PAUSE),
    .level(speed_level),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else begin
      unique case (state)
        ST_IDLE:  if (start) state <= ST_PLAY;
        ST_PLAY:  if (sweep_done && missed > 8'(MISS_LIMIT)) state <= ST_OVER;
                  else if (pause_sw) state <= ST_PAUSE;
        ST_PAUSE: if (!pause_sw) state <= ST_PLAY;
        ST_OVER:  if (start) state <= ST_PLAY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_req     <= 1'b0;
      upd_slot    <= '0;
      sweep_done  <= 1'b0;
      overrun     <= 1'b0;
      score       <= '0;
      high_score  <= '0;
      missed      <= '0;
      speed_level <= '0;
    end else begin
      sweep_done <= ack && last;
      if (ack) begin
        upd_req <= !last;
        if (!last) upd_slot <= upd_slot + 3'd1;
      end else if (tick && !upd_req) begin
        upd_req  <= 1'b1;
        upd_slot <= '0;
      end
      overrun     <= go ? 1'b0 : overrun | (tick & upd_req);
      score       <= go ? '0 : hit ? sat_add(score, upd_bonus ? 2'd2 : 2'd1, SCORE_MAX) : score;
      missed      <= go ? '0 : miss ? sat_add(missed, 2'd1, SCORE_MAX) : missed;
      high_score  <= (score > high_score) ? score : high_score;
      speed_level <= go ? '0 : sweep_done ? level_of(score) : speed_level;
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios with a behavioural datapath responder and hand-computed expectations
module tb_game_sequencer;
  logic clk = 0, reset = 0, start = 0, pause_sw = 0;
  logic ack_r = 0, stray_ack = 0, upd_caught = 0, upd_bonus = 0, upd_missed = 0;
  logic upd_ack, upd_req, sweep_done, overrun;
  logic [2:0] upd_slot;
  logic [1:0] game_state, speed_level;
  logic [7:0] score, high_score, missed;
  int checks = 0, failures = 0;
  int hs_count = 0, sd_count = 0, req_seen = 0, stab_err = 0, wait_cnt = 0, need = 0;
  int stall_slot = 7, stall_len = 0;
  logic prev_req = 0, prev_ack = 0;
  logic [2:0] prev_slot = 0;
  logic [2:0] slot_log [0:63];
  assign upd_ack = ack_r | stray_ack;
  always #5 clk = ~clk;
  game_sequencer #(.NUM_SLOTS(5), .TICK_DIV(8), .MISS_LIMIT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .pause_sw(pause_sw),
    .upd_req(upd_req), .upd_slot(upd_slot), .upd_ack(upd_ack),
    .upd_caught(upd_caught), .upd_bonus(upd_bonus), .upd_missed(upd_missed),
    .game_state(game_state), .score(score), .high_score(high_score), .missed(missed),
    .speed_level(speed_level), .sweep_done(sweep_done), .overrun(overrun)
  );
  // datapath model: acks after `need` extra cycles, logs every handshake
  always @(negedge clk) begin
    if (sweep_done) sd_count++;
    if (upd_req) req_seen++;
    if (upd_req && prev_req && !prev_ack && upd_slot != prev_slot) stab_err++;
    prev_req = upd_req;
    prev_slot = upd_slot;
    if (upd_req) begin
      need = (int'(upd_slot) == stall_slot) ? stall_len : 0;
      if (wait_cnt >= need) begin
        ack_r = 1;
        slot_log[hs_count % 64] = upd_slot;
        hs_count++;
        wait_cnt = 0;
      end else begin
        ack_r = 0;
        wait_cnt++;
      end
    end else begin
      ack_r = 0;
      wait_cnt = 0;
    end
    prev_ack = ack_r;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    pause_sw = 0;
    stall_slot = 7;
    stall_len = 0;
    tick();
    tick();
    reset = 1;
    hs_count = 0;
    sd_count = 0;
    req_seen = 0;
    stab_err = 0;
  endtask
  task automatic wait_sd(input int n, input int budget);
    for (int i = 0; i < budget && sd_count < n; i++) tick();
    checks++;
    if (sd_count < n) begin failures++; $display("FAIL sweep_done_timeout: got %0d required %0d", sd_count, n); end
  endtask
  task automatic check_slots();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (slot_log[i] !== 3'(i)) begin failures++; $display("FAIL slot_order[%0d]: got %0d required %0d", i, slot_log[i], i); end
    end
  endtask
  task automatic test_reset();
    reset = 0;
    tick();
    tick();
    checks++;
    if ({game_state, score, high_score, missed, speed_level, upd_req, sweep_done, overrun} !== 37'd0) begin
      failures++; $display("FAIL reset_outputs: got state=%0d score=%0d req=%0d", game_state, score, upd_req);
    end
    reset = 1;
    req_seen = 0;
    upd_caught = 1;
    stray_ack = 1;
    repeat (50) tick();
    stray_ack = 0;
    checks++;
    if (req_seen !== 0) begin failures++; $display("FAIL idle_no_req: got %0d required 0", req_seen); end
    checks++;
    if (score !== 8'd0) begin failures++; $display("FAIL stray_ack_ignored: got %0d required 0", score); end
    checks++;
    if (game_state !== 2'd0) begin failures++; $display("FAIL idle_state: got %0d required 0", game_state); end
  endtask
  task automatic test_sweep();
    do_reset();
    upd_caught = 1; upd_bonus = 0; upd_missed = 0;
    pulse_start();
    checks++;
    if (game_state !== 2'd1) begin failures++; $display("FAIL start_play: got %0d required 1", game_state); end
    wait_sd(1, 100);
    check_slots();
    checks++;
    if (hs_count !== 5) begin failures++; $display("FAIL handshakes: got %0d required 5", hs_count); end
    checks++;
    if (score !== 8'd5) begin failures++; $display("FAIL score_sweep1: got %0d required 5", score); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL no_overrun_lvl0: got %0d required 0", overrun); end
    wait_sd(2, 100);
    checks++;
    if (score !== 8'd10) begin failures++; $display("FAIL score_sweep2: got %0d required 10", score); end
    checks++;
    if (speed_level !== 2'd1) begin failures++; $display("FAIL speed_lvl1: got %0d required 1", speed_level); end
    repeat (30) tick();
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_period4: got %0d required 1", overrun); end
  endtask
  task automatic test_overrun();
    do_reset();
    upd_caught = 1; upd_bonus = 0; upd_missed = 0;
    stall_slot = 2;
    stall_len = 20;
    pulse_start();
    wait_sd(1, 200);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_stall: got %0d required 1", overrun); end
    checks++;
    if (hs_count !== 5) begin failures++; $display("FAIL stall_handshakes: got %0d required 5", hs_count); end
    check_slots();
    checks++;
    if (stab_err !== 0) begin failures++; $display("FAIL req_stable: got %0d required 0", stab_err); end
    tick();
    tick();
    checks++;
    if (sd_count !== 1) begin failures++; $display("FAIL single_sweep_done: got %0d required 1", sd_count); end
  endtask
  task automatic test_game_over();
    do_reset();
    upd_caught = 1; upd_bonus = 0; upd_missed = 0;
    pulse_start();
    wait_sd(1, 100);
    upd_missed = 1;
    for (int i = 0; i < 400 && game_state !== 2'd3; i++) tick();
    checks++;
    if (game_state !== 2'd3) begin failures++; $display("FAIL over_state: got %0d required 3", game_state); end
    checks++;
    if (sd_count !== 4) begin failures++; $display("FAIL over_at_sweep4: got %0d required 4", sd_count); end
    checks++;
    if (missed !== 8'd15) begin failures++; $display("FAIL missed_15: got %0d required 15", missed); end
    checks++;
    if (score !== 8'd5) begin failures++; $display("FAIL caught_missed_is_miss: got %0d required 5", score); end
    repeat (30) tick();
    checks++;
    if (hs_count !== 20) begin failures++; $display("FAIL no_req_in_over: got %0d required 20", hs_count); end
    pulse_start();
    checks++;
    if ({game_state, score, missed, speed_level, overrun} !== {2'd1, 8'd0, 8'd0, 2'd0, 1'b0}) begin
      failures++; $display("FAIL restart_clear: got state=%0d score=%0d missed=%0d", game_state, score, missed);
    end
    checks++;
    if (high_score !== 8'd5) begin failures++; $display("FAIL high_kept: got %0d required 5", high_score); end
  endtask
  task automatic test_pause();
    int n;
    do_reset();
    upd_caught = 1; upd_bonus = 0; upd_missed = 0;
    pulse_start();
    for (int i = 0; i < 100 && !(upd_req && upd_slot == 3'd1); i++) tick();
    pause_sw = 1;
    wait_sd(1, 50);
    checks++;
    if (hs_count !== 5) begin failures++; $display("FAIL pause_sweep_finishes: got %0d required 5", hs_count); end
    repeat (30) tick();
    checks++;
    if (game_state !== 2'd2) begin failures++; $display("FAIL pause_state: got %0d required 2", game_state); end
    checks++;
    if (hs_count !== 5) begin failures++; $display("FAIL pause_no_tick: got %0d required 5", hs_count); end
    pause_sw = 0;
    n = 0;
    for (int i = 0; i < 50 && !upd_req; i++) begin tick(); n++; end
    checks++;
    if (n !== 7) begin failures++; $display("FAIL resume_held_count: got %0d required 7", n); end
    checks++;
    if (game_state !== 2'd1) begin failures++; $display("FAIL resume_state: got %0d required 1", game_state); end
  endtask
  task automatic test_saturation();
    do_reset();
    upd_caught = 1; upd_bonus = 1; upd_missed = 0;
    pulse_start();
    for (int i = 0; i < 3000 && hs_count < 49; i++) tick();
    checks++;
    if (score !== 8'd98) begin failures++; $display("FAIL score_98: got %0d required 98", score); end
    for (int i = 0; i < 200 && hs_count < 50; i++) tick();
    checks++;
    if (score !== 8'd99) begin failures++; $display("FAIL score_sat: got %0d required 99", score); end
    tick();
    checks++;
    if (high_score !== 8'd99) begin failures++; $display("FAIL high_99: got %0d required 99", high_score); end
    for (int i = 0; i < 200 && hs_count < 52; i++) tick();
    checks++;
    if (score !== 8'd99) begin failures++; $display("FAIL score_stays_99: got %0d required 99", score); end
    checks++;
    if (speed_level !== 2'd3) begin failures++; $display("FAIL speed_lvl3: got %0d required 3", speed_level); end
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_overrun();
    test_game_over();
    test_pause();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
